mem_arbiter: RTL

Single-port memory arbiter letting the pipelined RiSC-16 core run from one unified instruction/data memory. It sits between the core's fetch port, the core's load/store port and one `mem_data`-style synchronous memory with 1-cycle read latency. Each cycle it grants at most one requester and routes the returned read word to the port that issued it. The data port has priority, and a starvation guard keeps fetch progressing.

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch and load/store share one 1-cycle-latency memory.
// Optional grant/conflict statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
  parameter int unsigned p_WORD_LEN     = 16,
  parameter int unsigned p_ADDR_LEN     = 16,
  parameter int unsigned p_STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [p_ADDR_LEN-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rd_valid,
  output logic [p_WORD_LEN-1:0] o_if_rd_data,
  input  logic                  i_d_req,
  input  logic                  i_d_wr_en,
  input  logic [p_ADDR_LEN-1:0] i_d_addr,
  input  logic [p_WORD_LEN-1:0] i_d_wr_data,
  output logic                  o_d_gnt,
  output logic                  o_d_rd_valid,
  output logic [p_WORD_LEN-1:0] o_d_rd_data,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic                  o_mem_wr_en,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
`ifdef MEM_ARB_STATS_EN
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
  output logic [31:0]           o_cnt_if_gnt,
  output logic [31:0]           o_cnt_d_gnt,
  output logic [31:0]           o_cnt_conflict
`else
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DATA} owner_e;

  localparam logic [3:0] STARVE_MAX = 4'(p_STARVE_LIMIT);

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       force_if;

  // Grant: a starved fetch beats data, otherwise data has priority.
  always_comb begin
    force_if = (starve_q == STARVE_MAX) && i_if_req;
    o_if_gnt = force_if || (i_if_req && !i_d_req);
    o_d_gnt  = i_d_req && !force_if;
  end

  always_comb begin
    o_mem_addr    = '0;
    o_mem_wr_data = '0;
    if (o_d_gnt) begin
      o_mem_addr    = i_d_addr;
      o_mem_wr_data = i_d_wr_data;
    end else if (o_if_gnt) begin
      o_mem_addr = i_if_addr;
    end
    o_mem_wr_en = o_d_gnt && i_d_wr_en;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (o_if_gnt)
      owner_d = OWN_IF;
    else if (o_d_gnt && !i_d_wr_en)
      owner_d = OWN_DATA;

    starve_d = '0;
    if (i_if_req && !o_if_gnt)
      starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
  end

  always_comb begin
    o_if_rd_valid = (owner_q == OWN_IF);
    o_d_rd_valid  = (owner_q == OWN_DATA);
    o_if_rd_data  = o_if_rd_valid ? i_mem_rd_data : '0;
    o_d_rd_data   = o_d_rd_valid  ? i_mem_rd_data : '0;
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] cnt_if_q, cnt_d_q, cnt_conf_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_if_q   <= '0;
      cnt_d_q    <= '0;
      cnt_conf_q <= '0;
    end else begin
      if (o_if_gnt && cnt_if_q != '1)
        cnt_if_q <= cnt_if_q + 32'd1;
      if (o_d_gnt && cnt_d_q != '1)
        cnt_d_q <= cnt_d_q + 32'd1;
      if (i_if_req && i_d_req && cnt_conf_q != '1)
        cnt_conf_q <= cnt_conf_q + 32'd1;
    end
  end

  assign o_cnt_if_gnt   = cnt_if_q;
  assign o_cnt_d_gnt    = cnt_d_q;
  assign o_cnt_conflict = cnt_conf_q;
`endif

endmodule
